// File: rtl/cmp_unit_pipe_if.sv
// Compare-unit issue/writeback bus: operands and tags in, CR-field result out.
// The slave modport is the compare unit's view; the master is the issuer/consumer.
interface cmp_unit_pipe_if #(
  parameter int XLEN        = 32,
  parameter int RS_ID_WIDTH = 5
);
  logic                   flush;
  logic                   input_valid;
  logic                   input_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_in;
  logic [2:0]             result_reg_addr_in;
  logic [XLEN-1:0]        op1;
  logic [XLEN-1:0]        op2;
  logic                   xer_so;
  logic                   cmp_signed;
  logic                   cmp_wide;
  logic                   cmp_eqb;
  logic                   output_valid;
  logic                   output_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_out;
  logic [2:0]             result_reg_addr_out;
  logic [3:0]             result;

  modport master (
    output flush, input_valid, rs_id_in, result_reg_addr_in, op1, op2,
           xer_so, cmp_signed, cmp_wide, cmp_eqb, output_ready,
    input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result
  );

  modport slave (
    input  flush, input_valid, rs_id_in, result_reg_addr_in, op1, op2,
           xer_so, cmp_signed, cmp_wide, cmp_eqb, output_ready,
    output input_ready, output_valid, rs_id_out, result_reg_addr_out, result
  );
endinterface

// File: rtl/cmp_unit_pipe.sv
// Elastic pipelined CR compare unit producing {LT,GT,EQ,SO}.
// Define CMP_UNIT_EQB_EN to build the compare-equal-byte datapath.
module cmp_unit_pipe #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 2,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  cmp_unit_pipe_if.slave  bus
);
  localparam int NB = XLEN / 8;

  logic [STAGES-1:0]                  v;
  logic [STAGES-1:0]                  en;
  logic [STAGES-1:0][RS_ID_WIDTH-1:0] id_q;
  logic [STAGES-1:0][2:0]             addr_q;
  logic [STAGES-1:1][3:0]             res_q;
  logic [STAGES-1:1][3:0]             res_d;

  logic [XLEN-1:0] op1_q, op2_q;
  logic            so_q, sgn_q, wide_q;

  logic signed [32:0]   na, nb;
  logic signed [XLEN:0] wa, wb;
  logic                 use_wide, lt, eq;
  logic [3:0]           cmp_res;

  // A stage advances unless it and every stage below it are full while the
  // consumer stalls; written per stage to keep the chain free of feedback.
  always_comb begin
    logic full;
    en = '0;
    for (int i = 0; i < STAGES; i++) begin
      full = 1'b1;
      for (int j = i; j < STAGES; j++) full = full & v[j];
      en[i] = ~full | bus.output_ready;
    end
  end

  assign bus.input_ready = en[0] & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (bus.flush) begin
      v <= '0;
    end else begin
      if (en[0]) v[0] <= bus.input_valid;
      for (int i = 1; i < STAGES; i++)
        if (en[i]) v[i] <= v[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      so_q      <= 1'b0;
      sgn_q     <= 1'b0;
      wide_q    <= 1'b0;
      id_q[0]   <= '0;
      addr_q[0] <= '0;
    end else if (en[0]) begin
      op1_q     <= bus.op1;
      op2_q     <= bus.op2;
      so_q      <= bus.xer_so;
      sgn_q     <= bus.cmp_signed;
      wide_q    <= bus.cmp_wide;
      id_q[0]   <= bus.rs_id_in;
      addr_q[0] <= bus.result_reg_addr_in;
    end
  end

`ifdef CMP_UNIT_EQB_EN
  logic          eqb_q;
  logic [NB-1:0] byte_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         eqb_q <= 1'b0;
    else if (en[0])  eqb_q <= bus.cmp_eqb;
  end

  for (genvar b = 0; b < NB; b++) begin : g_beq
    assign byte_eq[b] = (op2_q[8*b +: 8] == op1_q[7:0]);
  end
`else
  logic unused_eqb;
  assign unused_eqb = bus.cmp_eqb;
`endif

  // Extension bit is the operand sign when signed, zero when logical, so one
  // signed comparator serves both modes.
  always_comb begin
    na       = {sgn_q & op1_q[31], op1_q[31:0]};
    nb       = {sgn_q & op2_q[31], op2_q[31:0]};
    wa       = {sgn_q & op1_q[XLEN-1], op1_q};
    wb       = {sgn_q & op2_q[XLEN-1], op2_q};
    use_wide = wide_q & (XLEN > 32);
    if (use_wide) begin
      lt = (wa < wb);
      eq = (wa == wb);
    end else begin
      lt = (na < nb);
      eq = (na == nb);
    end
    cmp_res = {lt, ~(lt | eq), eq, so_q};
`ifdef CMP_UNIT_EQB_EN
    if (eqb_q) cmp_res = {1'b0, |byte_eq, 2'b00};
`endif
  end

  always_comb begin
    res_d    = '0;
    res_d[1] = cmp_res;
    for (int i = 2; i < STAGES; i++) res_d[i] = res_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      for (int i = 1; i < STAGES; i++) begin
        id_q[i]   <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          res_q[i]  <= res_d[i];
          id_q[i]   <= id_q[i-1];
          addr_q[i] <= addr_q[i-1];
        end
      end
    end
  end

  assign bus.output_valid        = v[STAGES-1];
  assign bus.result              = res_q[STAGES-1];
  assign bus.rs_id_out           = id_q[STAGES-1];
  assign bus.result_reg_addr_out = addr_q[STAGES-1];
endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Directed bench: 32-bit/2-stage and 64-bit/4-stage compare units side by side.
module tb_cmp_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cmp_unit_pipe_if #(.XLEN(32), .RS_ID_WIDTH(5)) b32();
  cmp_unit_pipe_if #(.XLEN(64), .RS_ID_WIDTH(5)) b64();

  cmp_unit_pipe #(.XLEN(32), .STAGES(2), .RS_ID_WIDTH(5)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  cmp_unit_pipe #(.XLEN(64), .STAGES(4), .RS_ID_WIDTH(5)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

  task automatic idle();
    b32.flush = 0; b32.input_valid = 0; b32.rs_id_in = 0; b32.result_reg_addr_in = 0;
    b32.op1 = 0; b32.op2 = 0; b32.xer_so = 0; b32.cmp_signed = 0; b32.cmp_wide = 0;
    b32.cmp_eqb = 0; b32.output_ready = 1;
    b64.flush = 0; b64.input_valid = 0; b64.rs_id_in = 0; b64.result_reg_addr_in = 0;
    b64.op1 = 0; b64.op2 = 0; b64.xer_so = 0; b64.cmp_signed = 0; b64.cmp_wide = 0;
    b64.cmp_eqb = 0; b64.output_ready = 1;
  endtask

  // Offers one op on the 64-bit unit, waits for its result, then lets it drain.
  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic so,
                         input logic sg, input logic w, input logic eqb,
                         input logic [4:0] id, input logic [2:0] ad,
                         output logic [3:0] res, output logic [4:0] oid, output int lat);
    int guard = 0;
    b64.op1 = a; b64.op2 = b; b64.xer_so = so; b64.cmp_signed = sg; b64.cmp_wide = w;
    b64.cmp_eqb = eqb; b64.rs_id_in = id; b64.result_reg_addr_in = ad;
    b64.input_valid = 1; b64.output_ready = 1; b64.flush = 0;
    #1;
    while (b64.input_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    b64.input_valid = 0;
    lat = 1;
    while (b64.output_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    res = b64.result; oid = b64.rs_id_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    n_cmp++; if (b32.output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov32 got %b want 0", b32.output_valid); end
    n_cmp++; if (b32.input_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ir32 got %b want 1", b32.input_ready); end
    n_cmp++; if (b64.output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov64 got %b want 0", b64.output_valid); end
    n_cmp++; if (b64.result !== 4'b0) begin n_bad++; $display("FAIL reset_res64 got %b want 0000", b64.result); end
    n_cmp++; if (b64.rs_id_out !== 5'd0) begin n_bad++; $display("FAIL reset_id64 got %0d want 0", b64.rs_id_out); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_compare32();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic        tso [4];
    logic        tsg [4];
    logic [3:0]  texp [4];
    int lat;
    ta   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00001234};
    tb   = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h00001234};
    tso  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tsg  = '{1'b1, 1'b0, 1'b1, 1'b0};
    texp = '{4'b1001, 4'b0101, 4'b0100, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      b32.op1 = ta[k]; b32.op2 = tb[k]; b32.xer_so = tso[k]; b32.cmp_signed = tsg[k];
      b32.cmp_wide = 1'b1; b32.rs_id_in = 5'(k + 1); b32.input_valid = 1; b32.output_ready = 1;
      #1;
      n_cmp++; if (b32.input_ready !== 1'b1) begin n_bad++; $display("FAIL cmp32_ready[%0d] got %b want 1", k, b32.input_ready); end
      @(posedge clk); #1;
      b32.input_valid = 0;
      lat = 1;
      while (b32.output_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL cmp32_latency[%0d] got %0d want 2", k, lat); end
      n_cmp++; if (b32.result !== texp[k]) begin n_bad++; $display("FAIL cmp32_result[%0d] got %b want %b", k, b32.result, texp[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_compare64();
    logic [63:0] ta [6];
    logic [63:0] tb [6];
    logic        tso [6];
    logic        tsg [6];
    logic        tw [6];
    logic [3:0]  texp [6];
    logic [3:0]  res;
    logic [4:0]  oid;
    int lat;
    ta   = '{64'h00000001_80000000, 64'h00000001_80000000, 64'h5, 64'h5,
             64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
    tb   = '{64'h0, 64'h0, 64'h5, 64'h5, 64'h0, 64'h0};
    tso  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tsg  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tw   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    texp = '{4'b1000, 4'b0100, 4'b0010, 4'b0011, 4'b0010, 4'b0100};
    for (int k = 0; k < 6; k++) begin
      issue64(ta[k], tb[k], tso[k], tsg[k], tw[k], 1'b0, 5'(k + 7), 3'(k), res, oid, lat);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL cmp64_latency[%0d] got %0d want 4", k, lat); end
      n_cmp++; if (res !== texp[k]) begin n_bad++; $display("FAIL cmp64_result[%0d] got %b want %b", k, res, texp[k]); end
      n_cmp++; if (oid !== 5'(k + 7)) begin n_bad++; $display("FAIL cmp64_tag[%0d] got %0d want %0d", k, oid, k + 7); end
    end
  endtask

  task automatic test_eqb();
    logic [63:0] tb [4];
    logic        tso [4];
    logic [3:0]  texp [4];
    logic [3:0]  res;
    logic [4:0]  oid;
    int lat;
    tb  = '{64'h11223A44_55667788, 64'h0, 64'h3A000000_00000000, 64'h3A};
    tso = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CMP_UNIT_EQB_EN
    texp = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
`else
    texp = '{4'b1000, 4'b0100, 4'b1000, 4'b0011};
`endif
    for (int k = 0; k < 4; k++) begin
      issue64(64'h3A, tb[k], tso[k], 1'b1, 1'b1, 1'b1, 5'(k + 20), 3'd1, res, oid, lat);
      n_cmp++; if (res !== texp[k]) begin n_bad++; $display("FAIL eqb_result[%0d] got %b want %b", k, res, texp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] texp [6];
    logic [4:0] ids [6];
    logic [3:0] rs [6];
    int acc = 0, got = 0;
    logic r, ov, stable = 1'b1;
    logic [4:0] oid;
    logic [3:0] ores;
    texp = '{4'b1000, 4'b1000, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      b64.output_ready = (cyc >= 8);
      if (acc < 6) begin
        b64.input_valid = 1; b64.op1 = 64'(acc + 1); b64.op2 = 64'd3; b64.cmp_signed = 1;
        b64.cmp_wide = 1; b64.cmp_eqb = 0; b64.xer_so = 0;
        b64.rs_id_in = 5'(acc + 1); b64.result_reg_addr_in = 3'(acc + 1);
      end else b64.input_valid = 0;
      #1;
      r = b64.input_ready; ov = b64.output_valid; oid = b64.rs_id_out; ores = b64.result;
      if (cyc == 7) begin
        n_cmp++; if (acc != 4) begin n_bad++; $display("FAIL b2b_accepts_full got %0d want 4", acc); end
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full got %b want 0", r); end
        n_cmp++; if (ov !== 1'b1 || oid !== 5'd1) begin n_bad++; $display("FAIL b2b_head got ov=%b id=%0d want ov=1 id=1", ov, oid); end
      end
      if (cyc == 8) begin
        n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL b2b_release_ready got %b want 1", r); end
      end
      if (ov && !b64.output_ready && (oid !== 5'd1 || ores !== 4'b1000)) stable = 1'b0;
      @(posedge clk);
      if (b64.input_valid && r) acc++;
      if (ov && b64.output_ready) begin ids[got] = oid; rs[got] = ores; got++; end
      #1;
    end
    b64.input_valid = 0;
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL b2b_delivered got %0d want 6", got); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_stable got %b want 1", stable); end
    for (int k = 0; k < got; k++) begin
      n_cmp++; if (ids[k] !== 5'(k + 1) || rs[k] !== texp[k]) begin
        n_bad++; $display("FAIL b2b_order[%0d] got id=%0d res=%b want id=%0d res=%b", k, ids[k], rs[k], k + 1, texp[k]);
      end
    end
    n_cmp++; if (b64.output_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup got %b want 0", b64.output_valid); end
  endtask

  task automatic test_flush();
    logic [3:0] res;
    logic [4:0] oid;
    int lat;
    logic seen = 1'b0;
    b64.output_ready = 0;
    for (int k = 0; k < 3; k++) begin
      b64.input_valid = 1; b64.op1 = 64'd9; b64.op2 = 64'd1; b64.rs_id_in = 5'(11 + k);
      @(posedge clk); #1;
    end
    b64.input_valid = 0;
    @(posedge clk); #1;
    n_cmp++; if (b64.output_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid got %b want 1", b64.output_valid); end
    b64.flush = 1; b64.input_valid = 1; b64.rs_id_in = 5'd30;
    #1;
    n_cmp++; if (b64.input_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", b64.input_ready); end
    @(posedge clk); #1;
    b64.flush = 0; b64.input_valid = 0; b64.output_ready = 1;
    n_cmp++; if (b64.output_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cleared got %b want 0", b64.output_valid); end
    for (int k = 0; k < 6; k++) begin
      if (b64.output_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_dropped_offer got %b want 0", seen); end
    issue64(64'd2, 64'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd21, 3'd2, res, oid, lat);
    n_cmp++; if (lat != 4 || oid !== 5'd21 || res !== 4'b1000) begin
      n_bad++; $display("FAIL flush_next got lat=%0d id=%0d res=%b want lat=4 id=21 res=1000", lat, oid, res);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] res;
    logic [4:0] oid;
    int lat;
    b64.output_ready = 0;
    for (int k = 0; k < 4; k++) begin
      b64.input_valid = 1; b64.op1 = 64'd7; b64.op2 = 64'd3; b64.cmp_signed = 0; b64.cmp_wide = 1;
      b64.rs_id_in = 5'(k + 1); b64.result_reg_addr_in = 3'd5;
      @(posedge clk); #1;
    end
    b64.input_valid = 0;
    #2;
    n_cmp++; if (b64.output_valid !== 1'b1 || b64.result !== 4'b0100 || b64.input_ready !== 1'b0) begin
      n_bad++; $display("FAIL areset_pre got ov=%b res=%b ir=%b want ov=1 res=0100 ir=0", b64.output_valid, b64.result, b64.input_ready);
    end
    rst = 1; #1;
    n_cmp++; if (b64.output_valid !== 1'b0) begin n_bad++; $display("FAIL areset_ov got %b want 0", b64.output_valid); end
    n_cmp++; if (b64.result !== 4'b0) begin n_bad++; $display("FAIL areset_res got %b want 0000", b64.result); end
    n_cmp++; if (b64.rs_id_out !== 5'd0 || b64.result_reg_addr_out !== 3'd0) begin
      n_bad++; $display("FAIL areset_tags got id=%0d addr=%0d want 0 0", b64.rs_id_out, b64.result_reg_addr_out);
    end
    n_cmp++; if (b64.input_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready got %b want 1", b64.input_ready); end
    #1 rst = 0;
    issue64(64'd4, 64'd4, 1'b1, 1'b0, 1'b1, 1'b0, 5'd17, 3'd3, res, oid, lat);
    n_cmp++; if (lat != 4 || oid !== 5'd17 || res !== 4'b0011) begin
      n_bad++; $display("FAIL areset_after got lat=%0d id=%0d res=%b want lat=4 id=17 res=0011", lat, oid, res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_compare32();
    test_compare64();
    test_eqb();
    test_back_to_back();
    idle();
    test_flush();
    idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_unit_pipe.md
# cmp_unit_pipe

Parametrised, elastic-pipelined successor to the CR compare unit in the fixed-point execution cluster. It accepts one compare per cycle from its reservation station and produces a 4-bit CR-field result on the separate CR writeback bus. It adds:
- configurable operand width and pipeline depth;
- a 32-bit/64-bit compare mode (L bit);
- a pipeline flush;
- optional compare-equal-byte support.

## Interface
- XLEN, 32, operand width; legal values 32 or 64
- STAGES, 2, pipeline depth in register stages; legal range 2..8
- RS_ID_WIDTH, 5, reservation-station tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all in-flight operations
- input_valid  in  1  operation offered
- input_ready  out  1  operation accepted when input_valid & input_ready at clock edge
- rs_id_in  in  RS_ID_WIDTH  issuing tag
- result_reg_addr_in  in  3  destination CR field
- op1, op2  in  XLEN  operands (bit 0 = MSB)
- xer_so  in  1  XER summary overflow, sampled with the operands
- cmp_signed  in  1  1 = signed compare, 0 = logical
- cmp_wide  in  1  1 = XLEN-bit compare, 0 = low-32-bit compare; ignored when XLEN=32
- cmp_eqb  in  1  compare-equal-byte mode (see Configuration)
- output_valid  out  1  result present
- output_ready  in  1  consumer takes result when output_valid & output_ready
- rs_id_out  out  RS_ID_WIDTH  tag of presented result
- result_reg_addr_out  out  3  CR field of presented result
- result  out  4  CR field value {LT,GT,EQ,SO}

## Operation
- Stage 0 registers the operands, the mode bits, xer_so and the tags.
- The compare is combinational on the stage-0 registers. Its result is registered into stage 1.
- Stages 2..STAGES-1 carry the result, tags and valid unchanged. Outputs are driven from stage STAGES-1.
- Narrow compare (cmp_wide=0, or XLEN=32):
  - operands are bits XLEN-32..XLEN-1;
  - when signed, the sign is bit XLEN-32;
  - the compare is done on a 33-bit extension: sign bit when signed, 0 when logical.
- Wide compare: the full XLEN bits, on an (XLEN+1)-bit extension built the same way.
- Result:
  - LT=100, GT=010, EQ=001 in bits 0..2, exactly one set;
  - bit 3 = the registered xer_so.
- cmp_eqb:
  - GT = 1 if any byte of op2 (XLEN/8 bytes) equals op1 bits XLEN-8..XLEN-1;
  - LT = EQ = SO = 0;
  - cmp_signed and cmp_wide are ignored.
- Per-stage valid v[i]. Stage i advances (en[i]) when it can take new contents, i.e. ~v[i] | en[i+1]. Stage STAGES-1 advances when ~v[STAGES-1] | output_ready.
- Bubbles collapse: an empty stage always accepts from the stage above.
- input_ready = ~v[0] | en[1]. It is combinational, with no dependency on input_valid.
- flush:
  - at the edge where flush=1, all v[i] clear to 0;
  - input is not accepted that cycle, and input_ready is 0 while flush=1;
  - an output handshake in the same cycle still counts as delivered.
- Data and tag registers load only when their stage advances. Bubble contents are don't-care but must not change outputs while output_valid=1 and output_ready=0.

## Timing
- Latency: STAGES cycles from accept edge to output_valid=1, with no stall.
- Throughput: 1 op/cycle with output_ready held high.
- Stall (output_ready=0 while output_valid=1):
  - result, rs_id_out and result_reg_addr_out hold stable;
  - upper stages fill;
  - input_ready drops only when all STAGES stages are valid.
- Capacity: STAGES operations in flight.
- Stall release: with the pipe full and output_ready rising, input_ready is 1 in that same cycle, and accept and deliver happen on the same edge.
- Reset, asserted at any time, including mid-stall: immediately (no clock edge needed) all v[i]=0, output_valid=0, result=0, rs_id_out=0, result_reg_addr_out=0, and hence input_ready=1.
- Reset deassertion: first accept possible on the first edge after rst falls.

## Configuration
- CMP_UNIT_EQB_EN defined:
  - cmp_eqb behaves as in Operation;
  - the byte-equality comparators are instantiated.
- CMP_UNIT_EQB_EN undefined:
  - cmp_eqb is ignored, and the op uses the normal compare selected by cmp_signed and cmp_wide;
  - no byte comparators are instantiated;
  - the port remains.

## Test plan
- Signed compare, XLEN=32, STAGES=2: op1=0xFFFFFFFF, op2=0x00000001, xer_so=1, cmp_signed=1 -> result=4'b1001 exactly 2 cycles after accept. Same operands with cmp_signed=0 -> 4'b0101.
- XLEN=64, cmp_wide=0, cmp_signed=1: op1=0x00000001_80000000, op2=0 -> 4'b1000. Same operands with cmp_wide=1 -> 4'b0100. op1=op2=0x5 -> 4'b0010.
- Back-pressure, STAGES=4: 6 ops issued back-to-back with output_ready=0 -> input_ready=0 after 4 accepts; output stable for the first op. output_ready=1 thereafter -> all 6 delivered in order with their tags; no drop, no duplicate.
- Flush with 3 ops in flight, STAGES=4 -> output_valid=0 the cycle after flush. An op offered during the flush cycle is not accepted. The next accepted op appears 4 cycles later.
- Async reset pulsed between clock edges while the pipe is full -> outputs cleared before the next edge; input_ready=1.
- With CMP_UNIT_EQB_EN, XLEN=64: op1 low byte=0x3A, op2=0x11223A4455667788, cmp_eqb=1 -> result=4'b0100. Same with op2=0 -> 4'b0000. Without the macro, the same stimulus gives the normal-compare result.
